dot_product_accumulator: RTL and testbench



---
 rtl/dot_product_accumulator_if.sv | 32 +++
 rtl/dot_product_accumulator.sv | 118 +++++++++++
 tb/tb_dot_product_accumulator.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/dot_product_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module   : dot_product_accumulator_if
// Brief    : Product-in / result-out handshake bundle for the accumulate stage.
// Revision : 1.0 - initial release
// ============================================================================
interface dot_product_accumulator_if #(
    parameter int WIDTH     = 9,
    parameter int GUARD     = 8,
    parameter int CNT_WIDTH = 16
);
    logic [2*WIDTH-1:0]       p_in;
    logic                     p_valid;
    logic                     p_last;
    logic                     p_ready;
    logic [2*WIDTH+GUARD-1:0] acc_out;
    logic [CNT_WIDTH-1:0]     cnt_out;
    logic                     ovf_out;
    logic                     out_valid;
    logic                     out_ready;

    modport master (
        output p_in, p_valid, p_last, out_ready,
        input  p_ready, acc_out, cnt_out, ovf_out, out_valid
    );

    modport slave (
        input  p_in, p_valid, p_last, out_ready,
        output p_ready, acc_out, cnt_out, ovf_out, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/dot_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : dot_product_accumulator
// Brief    : Accumulates a stream of unsigned products into dot-product results.
// Revision : 1.0 - initial release
// ============================================================================
module dot_product_accumulator #(
    parameter int WIDTH     = 9,
    parameter int GUARD     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  wire logic                clk_i,
    input  wire logic                rst_n_i,
    dot_product_accumulator_if.slave bus
);
    localparam int P_WIDTH   = 2 * WIDTH;
    localparam int ACC_WIDTH = P_WIDTH + GUARD;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic [ACC_WIDTH-1:0]   acc_out_q, acc_out_d;
    logic [CNT_WIDTH-1:0]   cnt_out_q, cnt_out_d;
    logic                   ovf_out_q, ovf_out_d;
    logic                   out_valid_q, out_valid_d;

    logic                   p_ready;
    logic                   in_beat;
    logic [ACC_WIDTH:0]     sum_ext;
    logic [ACC_WIDTH-1:0]   next_acc;
    logic [CNT_WIDTH-1:0]   next_cnt;
    logic                   next_ovf;

    // Input stalls only while a finished result is waiting to be taken.
    assign p_ready  = !out_valid_q || bus.out_ready;
    assign in_beat  = bus.p_valid && p_ready;
    assign sum_ext  = {1'b0, acc_q} + {{(GUARD + 1){1'b0}}, bus.p_in};

    always_comb begin
        next_acc = acc_q;
        next_cnt = cnt_q;
        next_ovf = ovf_q;
        if (state_q == IDLE) begin
            next_acc = {{GUARD{1'b0}}, bus.p_in};
            next_cnt = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            next_ovf = 1'b0;
        end else begin
            next_acc = sum_ext[ACC_WIDTH-1:0];
            next_ovf = ovf_q | sum_ext[ACC_WIDTH];
            next_cnt = (cnt_q == {CNT_WIDTH{1'b1}}) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        acc_out_d   = acc_out_q;
        cnt_out_d   = cnt_out_q;
        ovf_out_d   = ovf_out_q;
        out_valid_d = out_valid_q;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (in_beat) begin
            acc_d = next_acc;
            cnt_d = next_cnt;
            ovf_d = next_ovf;
            if (bus.p_last) begin
                acc_out_d   = next_acc;
                cnt_out_d   = next_cnt;
                ovf_out_d   = next_ovf;
                out_valid_d = 1'b1;
                state_d     = IDLE;
            end else begin
                state_d     = ACCUM;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            acc_out_q   <= '0;
            cnt_out_q   <= '0;
            ovf_out_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            acc_out_q   <= acc_out_d;
            cnt_out_q   <= cnt_out_d;
            ovf_out_q   <= ovf_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.p_ready   = p_ready;
    assign bus.acc_out   = acc_out_q;
    assign bus.cnt_out   = cnt_out_q;
    assign bus.ovf_out   = ovf_out_q;
    assign bus.out_valid = out_valid_q;
endmodule
`default_nettype wire

// File: tb/tb_dot_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_dot_product_accumulator
// Brief    : Scoreboard bench for dot_product_accumulator with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dot_product_accumulator;
    localparam int WIDTH     = 9;
    localparam int GUARD     = 8;
    localparam int CNT_WIDTH = 16;
    localparam int ACC_WIDTH = 2 * WIDTH + GUARD;
    localparam int EXP_W     = ACC_WIDTH + CNT_WIDTH + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rnd_mode = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;

    logic [EXP_W-1:0] exp_q[$];
    logic [EXP_W-1:0] mon_e;

    dot_product_accumulator_if #(.WIDTH(WIDTH), .GUARD(GUARD), .CNT_WIDTH(CNT_WIDTH)) bus();

    dot_product_accumulator #(.WIDTH(WIDTH), .GUARD(GUARD), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [EXP_W-1:0] mk(input logic [ACC_WIDTH-1:0] a,
                                            input logic [CNT_WIDTH-1:0] c,
                                            input logic o);
        return {a, c, o};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    // Monitor: every output beat pops the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_result: got acc=%0d cnt=%0d, required no result",
                         bus.acc_out, bus.cnt_out);
            end else begin
                mon_e = exp_q.pop_front();
                chk("acc_out", 64'(bus.acc_out), 64'(mon_e[EXP_W-1:CNT_WIDTH+1]));
                chk("cnt_out", 64'(bus.cnt_out), 64'(mon_e[CNT_WIDTH:1]));
                chk("ovf_out", 64'(bus.ovf_out), 64'(mon_e[0]));
            end
        end
    end

    task automatic send(input int val, input bit last, output int waits);
        bus.p_in    = val[2*WIDTH-1:0];
        bus.p_valid = 1'b1;
        bus.p_last  = last;
        waits       = 0;
        forever begin
            @(negedge clk);
            if (bus.p_ready) break;
            waits++;
            if (waits > 200) begin
                n_total++;
                $display("FAIL send_timeout: got no p_ready in %0d cycles, required acceptance", waits);
                break;
            end
            @(posedge clk); #1;
            if (rnd_mode) bus.out_ready = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        bus.p_valid = 1'b0;
        bus.p_last  = 1'b0;
        if (rnd_mode) bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        int len;
        logic [ACC_WIDTH-1:0] sum;
        int a, b;

        bus.p_in = '0; bus.p_valid = 1'b0; bus.p_last = 1'b0; bus.out_ready = 1'b1;

        // Reset state
        #12;
        chk("rst_acc_out",   64'(bus.acc_out),   0);
        chk("rst_cnt_out",   64'(bus.cnt_out),   0);
        chk("rst_ovf_out",   64'(bus.ovf_out),   0);
        chk("rst_out_valid", 64'(bus.out_valid), 0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        chk("rst_p_ready", 64'(bus.p_ready), 1);
        @(posedge clk); #1;

        // Three-element vector, single-cycle valid
        exp_q.push_back(mk(26'd60, 16'd3, 1'b0));
        send(10, 1'b0, w);
        send(20, 1'b0, w);
        send(30, 1'b1, w);
        @(negedge clk); chk("t1_valid_high", 64'(bus.out_valid), 1);
        @(negedge clk); chk("t1_valid_low",  64'(bus.out_valid), 0);
        @(posedge clk); #1;

        // Back-to-back single-element vectors
        exp_q.push_back(mk(26'd5, 16'd1, 1'b0));
        exp_q.push_back(mk(26'd7, 16'd1, 1'b0));
        exp_q.push_back(mk(26'd9, 16'd1, 1'b0));
        send(5, 1'b1, w); chk("t2_ready_5", 64'(w), 0); chk("t2_valid_5", 64'(bus.out_valid), 1);
        send(7, 1'b1, w); chk("t2_ready_7", 64'(w), 0); chk("t2_valid_7", 64'(bus.out_valid), 1);
        send(9, 1'b1, w); chk("t2_ready_9", 64'(w), 0); chk("t2_valid_9", 64'(bus.out_valid), 1);
        @(negedge clk);
        @(posedge clk); #1;

        // Backpressure: result held, next vector stalled
        bus.out_ready = 1'b0;
        exp_q.push_back(mk(26'd300, 16'd2, 1'b0));
        send(100, 1'b0, w);
        send(200, 1'b1, w);
        exp_q.push_back(mk(26'd7, 16'd1, 1'b0));
        bus.p_in = 18'd7; bus.p_valid = 1'b1; bus.p_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3_p_ready_low",  64'(bus.p_ready),   0);
            chk("t3_valid_held",   64'(bus.out_valid), 1);
            chk("t3_acc_held",     64'(bus.acc_out),   300);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(negedge clk); chk("t3_p_ready_back", 64'(bus.p_ready), 1);
        @(posedge clk); #1;
        bus.p_valid = 1'b0; bus.p_last = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;

        // Overflow: 258 * 261121 = 67369218, wraps to 260354 mod 2^26
        exp_q.push_back(mk(26'd260354, 16'd258, 1'b1));
        for (int i = 0; i < 258; i++) send(261121, (i == 257), w);
        exp_q.push_back(mk(26'd1, 16'd1, 1'b0));
        send(1, 1'b1, w);

        // Reset mid-vector discards partial sum
        send(40, 1'b0, w);
        send(50, 1'b0, w);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_acc",   64'(bus.acc_out),   0);
        chk("t5_rst_cnt",   64'(bus.cnt_out),   0);
        chk("t5_rst_valid", 64'(bus.out_valid), 0);
        @(posedge clk); #1; rst_n = 1'b1;
        exp_q.push_back(mk(26'd3, 16'd1, 1'b0));
        send(3, 1'b1, w);

        // Randomised vectors through a multiplier model
        rnd_mode = 1'b1;
        for (int v = 0; v < 8; v++) begin
            len = int'($urandom_range(1, 20));
            sum = '0;
            for (int k = 0; k < len; k++) begin
                a = int'($urandom_range(0, 511));
                b = int'($urandom_range(0, 511));
                sum = sum + ACC_WIDTH'(a * b);
                if (k == len - 1) exp_q.push_back(mk(sum, CNT_WIDTH'(len), 1'b0));
                send(a * b, (k == len - 1), w);
            end
        end
        rnd_mode = 1'b0;
        bus.out_ready = 1'b1;

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
